// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator: DIGIT bits per cycle, early exit on the
// first differing digit, optional two's-complement ordering via MSB inversion.

module smc_digit_cmp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  output logic             lt,
  output logic             gt
);
  assign lt = (a_dig < b_dig);
  assign gt = (a_dig > b_dig);
endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    k_q;
  logic             l_q, e_q, g_q;
  logic             dig_lt, dig_gt, last_dig;

  // Operands shift left each CMP cycle, so the current digit is always on top.
  smc_digit_cmp #(.DIGIT(DIGIT)) u_dig (
    .a_dig (a_q[WIDTH-1 -: DIGIT]),
    .b_dig (b_q[WIDTH-1 -: DIGIT]),
    .lt    (dig_lt),
    .gt    (dig_gt)
  );

  assign last_dig = (k_q == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (dig_lt || dig_gt || last_dig) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      l_q   <= 1'b0;
      e_q   <= 1'b0;
      g_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q <= signed_mode ? {~A[WIDTH-1], A[WIDTH-2:0]} : A;
            b_q <= signed_mode ? {~B[WIDTH-1], B[WIDTH-2:0]} : B;
            k_q <= '0;
            l_q <= 1'b0;
            e_q <= 1'b0;
            g_q <= 1'b0;
          end
        end
        CMP: begin
          if (dig_lt)        l_q <= 1'b1;
          else if (dig_gt)   g_q <= 1'b1;
          else if (last_dig) e_q <= 1'b1;
          else begin
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
            k_q <= k_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CMP);
  assign done = (state == DONE);
  assign L    = l_q;
  assign E    = e_q;
  assign G    = g_q;
endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range is 2 or more.
REQ-002 SHALL have parameter DIGIT, default 1, bits compared per cycle; legal values are 1 to WIDTH and SHALL divide WIDTH exactly.
REQ-003 SHALL have a single clock domain: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: start  input  1  request a comparison; sampled only in IDLE.
REQ-007 SHALL have port: signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-008 SHALL have port: A  input  WIDTH  first operand; sampled with start.
REQ-009 SHALL have port: B  input  WIDTH  second operand; sampled with start.
REQ-010 SHALL have port: busy  output  1  high while a comparison is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-012 SHALL have port: L  output  1  A < B.
REQ-013 SHALL have port: E  output  1  A == B.
REQ-014 SHALL have port: G  output  1  A > B.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CMP and DONE.
REQ-016 In IDLE with start=1, SHALL latch A, B and signed_mode into internal registers, clear L/E/G to 000, load digit index k=0 and move to CMP on that edge (accept cycle t).
REQ-017 In signed mode, SHALL invert the MSB of both latched operands at load so that the unsigned digit compare yields the signed order.
REQ-018 In CMP, SHALL compare one DIGIT-bit digit per cycle, MSB-first; digit k is compared in cycle t+1+k.
REQ-019 SHALL terminate early: on the first digit k where the operands differ, SHALL register L=1 (A digit smaller) or G=1 (A digit larger) and move to DONE.
REQ-020 If all N=WIDTH/DIGIT digits are equal, SHALL register E=1 after digit N-1 and move to DONE.
REQ-021 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-022 Latency SHALL be: done in cycle t+2+k for a first difference at digit k, and in cycle t+1+N when the operands are equal.
REQ-023 SHALL assert busy exactly while in CMP; busy SHALL be low in IDLE and in DONE.
REQ-024 SHALL hold L/E/G from the done cycle until the next accepted start; exactly one of them SHALL be 1 after any completion.
REQ-025 SHALL ignore start while in CMP or DONE; such a start SHALL not be queued.
REQ-026 SHALL make changes on A, B or signed_mode after acceptance have no effect on the result in progress.
REQ-027 SHALL use a digit counter of ceil(log2(N+1)) bits and SHALL NOT let it wrap within a single operation.

Reset
REQ-028 While rst=1 at a clock edge, SHALL force state=IDLE, busy=0, done=0 and L=E=G=0, clearing the latched operands and counter; rst SHALL take priority over start.
REQ-029 Reset asserted during CMP or DONE SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL operate normally.

Verification (WIDTH=8 unless stated; start accepted at cycle t)
REQ-030 SHALL cover: unsigned, A=11000011, B=11001011 -> first difference at k=4; done at t+6; L=1, E=0, G=0; busy high t+1..t+5.
REQ-031 SHALL cover: A=B=01001011 -> done at t+9; E=1, L=0, G=0.
REQ-032 SHALL cover: A=11111111, B=00000000 -> unsigned: done at t+2, G=1; signed_mode=1: done at t+2, L=1 (-1 < 0).
REQ-033 SHALL cover: start pulsed again during CMP and A/B changed after acceptance -> result and timing unchanged, exactly one done pulse.
REQ-034 SHALL cover: rst asserted at t+3 of an equal-operand compare -> no done; outputs 0/0/0/0; a new start then completes correctly.
REQ-035 SHALL cover: DIGIT=4, A=00000001, B=00000010 -> difference at k=1; done at t+3; L=1.
